// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch: issues sequential word reads on a pipelined memory
// port, presents each returned word with its PC and skids it across decoder stalls.
module rv32i_fetch #(
   parameter logic [31:0] RV32I_RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] RV32I_NOP          = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] iaddress,
   output logic        iread,
   input  logic        iwaitrequest,
   input  logic [31:0] ireaddata,
   input  logic        update_pc,
   input  logic [31:0] new_pc,
   input  logic        stall,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid
);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_word_t;

   logic [31:0] fetch_pc;
   logic [31:0] req_pc;
   logic        pending;
   logic        hold_valid;
   fetch_word_t hold;
   logic        run;      // low for the first cycle out of reset
   logic        accept;

   assign iaddress = fetch_pc;
   assign iread    = reset_n & run & ~stall & ~hold_valid & ~update_pc;
   assign accept   = iread & ~iwaitrequest;

   always_comb begin
      instr       = RV32I_NOP;
      pc          = fetch_pc;
      instr_valid = 1'b0;
      if (!update_pc) begin
         if (hold_valid) begin
            instr       = hold.instr;
            pc          = hold.pc;
            instr_valid = 1'b1;
         end else if (pending) begin
            instr       = ireaddata;
            pc          = req_pc;
            instr_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc   <= RV32I_RESET_VECTOR;
         req_pc     <= 32'h0;
         pending    <= 1'b0;
         hold_valid <= 1'b0;
         hold       <= '0;
         run        <= 1'b0;
      end else begin
         run <= 1'b1;
         if (update_pc) begin
            // redirect drops both the in-flight beat and any held word
            fetch_pc   <= {new_pc[31:2], 2'b00};
            pending    <= 1'b0;
            hold_valid <= 1'b0;
         end else begin
            pending <= accept;
            if (accept) begin
               req_pc   <= fetch_pc;
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (pending && stall && !hold_valid) begin
               hold.instr <= ireaddata;
               hold.pc    <= req_pc;
               hold_valid <= 1'b1;
            end else if (!stall) begin
               hold_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: cycle vector table for the directed corner cases plus a
// memory model and in-order scoreboard running under random stall/wait/redirect.
module tb_rv32i_fetch;

   localparam logic [31:0] KEY = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] iaddress;
   logic        iread;
   logic        iwaitrequest = 1'b0;
   logic [31:0] ireaddata = 32'h0;
   logic        update_pc = 1'b0;
   logic [31:0] new_pc = 32'h0;
   logic        stall = 1'b0;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;

   rv32i_fetch dut (
      .clk(clk), .reset_n(reset_n), .iaddress(iaddress), .iread(iread),
      .iwaitrequest(iwaitrequest), .ireaddata(ireaddata), .update_pc(update_pc),
      .new_pc(new_pc), .stall(stall), .instr(instr), .pc(pc), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rstn, stl, wt, upd;
      logic [31:0] npc;
      logic        e_iread;
      logic [31:0] e_iaddr;
      logic        e_valid;
      logic [31:0] e_pc, e_instr;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   vec_t        tbl[$];
   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          consumed = 0;
   logic        mem_acc = 1'b0;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] exp_fa = 32'h0;
   logic        prev_stall = 1'b0, prev_rstn = 1'b0, prev_upd = 1'b0, prev_valid = 1'b0;
   logic [31:0] prev_instr = 32'h0, prev_pc = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic rstn, input logic stl, input logic wt, input logic upd,
                      input logic [31:0] npc, input logic e_iread, input logic [31:0] e_iaddr,
                      input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_instr);
      vec_t v;
      v.rstn = rstn; v.stl = stl; v.wt = wt; v.upd = upd; v.npc = npc;
      v.e_iread = e_iread; v.e_iaddr = e_iaddr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_instr = e_instr;
      tbl.push_back(v);
   endtask

   // drive one cycle's inputs; memory returns the word for last cycle's accepted read
   task automatic apply(input logic rstn, input logic stl, input logic wt, input logic upd,
                        input logic [31:0] npc);
      @(negedge clk);
      ireaddata    = mem_acc ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
      reset_n      = rstn;
      stall        = stl;
      iwaitrequest = wt;
      update_pc    = upd;
      new_pc       = npc;
      #1;
   endtask

   // scoreboard and protocol bookkeeping on the values the next edge will sample
   task automatic account();
      exp_t e;
      if (!reset_n) begin
         sb.delete();
         exp_fa = 32'h0;
      end else begin
         if (instr_valid && !stall) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_word", instr_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("sb_pc", pc, e.pc);
               chk("sb_instr", instr, e.instr);
               consumed++;
            end
         end
         if (prev_stall && prev_rstn && !prev_upd && !update_pc) begin
            chk("stall_hold_instr", instr, prev_instr);
            chk("stall_hold_pc", pc, prev_pc);
            chk("stall_hold_valid", instr_valid, prev_valid);
         end
         if (stall) chk("stall_iread", iread, 1'b0);
         chk("iaddr_align", iaddress[1:0], 2'b00);
         if (update_pc) begin
            chk("redir_valid", instr_valid, 1'b0);
            chk("redir_instr", instr, NOP);
            sb.delete();
            exp_fa = {new_pc[31:2], 2'b00};
         end else if (iread && !iwaitrequest) begin
            chk("issue_addr", iaddress, exp_fa);
            e.pc = iaddress;
            e.instr = iaddress ^ KEY;
            sb.push_back(e);
            exp_fa = exp_fa + 32'd4;
         end
      end
      mem_acc    = reset_n & iread & ~iwaitrequest;
      mem_addr   = iaddress;
      prev_stall = stall;
      prev_rstn  = reset_n;
      prev_upd   = update_pc;
      prev_valid = instr_valid;
      prev_instr = instr;
      prev_pc    = pc;
   endtask

   initial begin
      //   rstn stl wt upd new_pc         iread iaddr          valid pc             instr
      add(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          NOP);
      add(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'hA5A5_0000);
      add(1, 0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h4,          32'hA5A5_0004);
      add(1, 0, 1, 0, 32'h0,          1, 32'h8,          0, 32'h8,          NOP);
      add(1, 0, 1, 0, 32'h0,          1, 32'h8,          0, 32'h8,          NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h8,          0, 32'h8,          NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'hC,          1, 32'h8,          32'hA5A5_0008);
      add(1, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'hC,          32'hA5A5_000C);
      add(1, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'hC,          32'hA5A5_000C);
      add(1, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'hC,          32'hA5A5_000C);
      add(1, 1, 0, 0, 32'h0,          0, 32'h10,         1, 32'hC,          32'hA5A5_000C);
      add(1, 0, 0, 0, 32'h0,          0, 32'h10,         1, 32'hC,          32'hA5A5_000C);
      add(1, 0, 0, 0, 32'h0,          1, 32'h10,         0, 32'h10,         NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h14,         1, 32'h10,         32'hA5A5_0010);
      add(1, 0, 0, 1, 32'h103,        0, 32'h18,         0, 32'h18,         NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h100,        0, 32'h100,        NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h104,        1, 32'h100,        32'hA5A5_0100);
      add(1, 1, 0, 0, 32'h0,          0, 32'h108,        1, 32'h104,        32'hA5A5_0104);
      add(1, 1, 0, 1, 32'hFFFF_FFFC,  0, 32'h108,        0, 32'h108,        NOP);
      add(1, 1, 0, 0, 32'h0,          0, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'hFFFF_FFFC,  NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h0,          1, 32'hFFFF_FFFC,  32'h5A5A_FFFC);
      add(0, 0, 0, 0, 32'h0,          0, 32'h4,          1, 32'h0,          32'hA5A5_0000);
      add(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,          NOP);
      add(1, 0, 0, 0, 32'h0,          1, 32'h4,          1, 32'h0,          32'hA5A5_0000);

      apply(0, 0, 0, 0, 32'h0);
      account();

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i].rstn, tbl[i].stl, tbl[i].wt, tbl[i].upd, tbl[i].npc);
         chk($sformatf("v%0d_iread", i), iread, tbl[i].e_iread);
         chk($sformatf("v%0d_iaddress", i), iaddress, tbl[i].e_iaddr);
         chk($sformatf("v%0d_valid", i), instr_valid, tbl[i].e_valid);
         chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
         chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
         account();
      end

      // random stall / wait / redirect traffic, checked by the scoreboard
      for (int i = 0; i < 600; i++) begin
         logic        s, w, u;
         logic [31:0] t;
         s = ($urandom_range(0, 9) < 3);
         w = ($urandom_range(0, 9) < 2);
         u = ($urandom_range(0, 24) == 0);
         t = ($urandom_range(0, 1) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
         apply((i != 300), s, w, u, t);
         account();
      end

      for (int i = 0; i < 6; i++) begin
         apply(1, 0, 0, 0, 32'h0);
         account();
      end
      chk("drain_outstanding", 32'(sb.size()), 32'd1);
      chk("random_progress", 32'(consumed > 150), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
